grf_wb_queue: RTL and testbench
===============================

GRF_WB_QUEUE -- requirements
Module: grf_wb_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, MDU write-queue entries (power of two, >=2).
REQ-002 SHALL have ports: clk  in  1  system clock, all state on rising edge.
REQ-003 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-004 SHALL have ports p_we in 1 / p_wt in 5 / p_wdata in 32 / p_pc in 32: pipeline W-stage write request, always accepted.
REQ-005 SHALL have ports m_valid in 1 / m_ready out 1 / m_wt in 5 / m_wdata in 32 / m_pc in 32: MDU write request, valid/ready handshake.
REQ-006 SHALL have ports alloc_valid in 1 / alloc_wt in 5: issue stage reserves a register for a pending MDU result.
REQ-007 SHALL have ports q_rs in 5 / q_rt in 5 / q_busy_rs out 1 / q_busy_rt out 1: scoreboard query, combinational.
REQ-008 SHALL have ports WE out 1 / wt out 5 / wdata out 32 / wPc out 32: registered GRF write port.
REQ-009 SHALL have port pending out $clog2(DEPTH+1): current queue occupancy.

Function
REQ-010 SHALL accept an MDU transfer at a rising edge where m_valid && m_ready; m_ready = (pending != DEPTH), no same-cycle enqueue-on-dequeue when full.
REQ-011 SHALL discard, without queueing, any MDU transfer with m_wt == 0 (handshake still completes).
REQ-012 SHALL drive the output register each edge with priority: pipeline write (p_we && p_wt != 0) > queue head > idle.
REQ-013 SHALL present a pipeline write on WE/wt/wdata/wPc exactly one cycle after it is sampled.
REQ-014 SHALL hold the queue head while a pipeline write owns the port; head dequeues at the first edge without one.
REQ-015 SHALL give an MDU write minimum latency two edges: enqueue at E0, output valid after E1.
REQ-016 SHALL drive WE=0 and hold wt/wdata/wPc at previous values on idle cycles.
REQ-017 SHALL commit queued writes in FIFO order; pointers wrap modulo DEPTH.
REQ-018 SHALL set busy[alloc_wt] on alloc_valid, ignoring alloc_wt == 0.
REQ-019 SHALL clear busy[wt] on the edge a queued entry is dequeued to the output.
REQ-020 SHALL let a set win over a clear when both target the same register on one edge.
REQ-021 SHALL report q_busy_* = busy[q_*]; register 0 always reads not busy.
REQ-022 SHALL treat pipeline writes as never touching the scoreboard.

Reset
REQ-023 SHALL on reset low, immediately: WE=0, wt=0, wdata=0, wPc=0, busy all 0, queue empty, pending=0, m_ready=1.
REQ-024 SHALL drop all queued entries if reset asserts mid-operation; no partial commit.

Configuration
REQ-025 SHALL, with GRF_WB_TRACE_EN defined, print "@<wPc hex>: $<wt dec> <= <wdata hex>" for each commit, on the edge it is loaded.
REQ-026 SHALL, without GRF_WB_TRACE_EN, contain no simulation prints; behaviour otherwise identical.

Structure
REQ-027 SHALL place in shared package grf_wb_pkg: entry typedef {wt[4:0], wdata[31:0], pc[31:0]}, constant REG_ZERO=5'd0.
REQ-028 SHALL implement the queue as sub-module wb_fifo (DEPTH entries, push/pop/full/empty/count).

Verification
REQ-029 SHALL check: pipeline write p_wt=5, p_wdata=0x1234, p_pc=0x3000 -> next cycle WE=1, wt=5, wdata=0x1234, wPc=0x3000.
REQ-030 SHALL check: alloc $8, MDU write $8=0xAA with p_we=0 -> busy_rs(8)=1 until dequeue; WE=1 wt=8 two edges after accept; busy clears.
REQ-031 SHALL check: MDU $9 accepted with p_we held 1 for 3 cycles -> $9 commits on 4th cycle, after the three pipeline writes.
REQ-032 SHALL check: 4 MDU writes under continuous pipeline writes -> m_ready=0, pending=4; 5th held; order preserved after drain.
REQ-033 SHALL check: p_wt=0 and m_wt=0 writes -> WE stays 0, pending unchanged.
REQ-034 SHALL check: reset asserted with pending=3 -> all outputs zero at once, queue empty, no commit after release.

Source files
------------

// File: rtl/grf_wb_pkg.sv
// Shared types and constants for the GRF write-back queue.
package grf_wb_pkg;

   typedef struct packed {
      logic [4:0]  wt;
      logic [31:0] wdata;
      logic [31:0] pc;
   } entry_t;

   localparam logic [4:0] REG_ZERO = 5'd0;

   function automatic logic is_live(input logic [4:0] r);
      return r != REG_ZERO;
   endfunction

endpackage

// File: rtl/wb_fifo.sv
// Circular FIFO holding pending MDU register writes; pointers wrap modulo DEPTH.
module wb_fifo
   import grf_wb_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         push,
   input  logic                         pop,
   input  entry_t                       din,
   output entry_t                       dout,
   output logic                         full,
   output logic                         empty,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   entry_t           mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/grf_wb_queue.sv
// GRF write-port arbiter: pipeline writes take priority, MDU results wait in a FIFO.
// Define GRF_WB_TRACE_EN to print a commit trace line for every register write.
module grf_wb_queue
   import grf_wb_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        p_we,
   input  logic [4:0]                  p_wt,
   input  logic [31:0]                 p_wdata,
   input  logic [31:0]                 p_pc,
   input  logic                        m_valid,
   output logic                        m_ready,
   input  logic [4:0]                  m_wt,
   input  logic [31:0]                 m_wdata,
   input  logic [31:0]                 m_pc,
   input  logic                        alloc_valid,
   input  logic [4:0]                  alloc_wt,
   input  logic [4:0]                  q_rs,
   input  logic [4:0]                  q_rt,
   output logic                        q_busy_rs,
   output logic                        q_busy_rt,
   output logic                        WE,
   output logic [4:0]                  wt,
   output logic [31:0]                 wdata,
   output logic [31:0]                 wPc,
   output logic [$clog2(DEPTH+1)-1:0]  pending
);

   logic        pipe_wr;
   logic        fifo_push;
   logic        fifo_pop;
   logic        fifo_full;
   logic        fifo_empty;
   entry_t      m_entry;
   entry_t      head;
   logic [31:0] busy;
   logic [31:0] set_mask;
   logic [31:0] clr_mask;

   assign pipe_wr   = p_we && is_live(p_wt);
   assign m_ready   = !fifo_full;
   // Writes to $0 still complete the handshake but never occupy a slot.
   assign fifo_push = m_valid && m_ready && is_live(m_wt);
   assign fifo_pop  = !pipe_wr && !fifo_empty;
   assign m_entry   = '{wt: m_wt, wdata: m_wdata, pc: m_pc};

   wb_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (fifo_push),
      .pop   (fifo_pop),
      .din   (m_entry),
      .dout  (head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (pending)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         WE    <= 1'b0;
         wt    <= '0;
         wdata <= '0;
         wPc   <= '0;
      end else if (pipe_wr) begin
         WE    <= 1'b1;
         wt    <= p_wt;
         wdata <= p_wdata;
         wPc   <= p_pc;
      end else if (fifo_pop) begin
         WE    <= 1'b1;
         wt    <= head.wt;
         wdata <= head.wdata;
         wPc   <= head.pc;
      end else begin
         WE    <= 1'b0;
      end
   end

   always_comb begin
      set_mask = '0;
      clr_mask = '0;
      if (fifo_pop) clr_mask[head.wt] = 1'b1;
      if (alloc_valid && is_live(alloc_wt)) set_mask[alloc_wt] = 1'b1;
   end

   // Set is OR-ed after the clear so a same-edge reallocation stays busy.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) busy <= '0;
      else        busy <= (busy & ~clr_mask) | set_mask;
   end

   assign q_busy_rs = is_live(q_rs) && busy[q_rs];
   assign q_busy_rt = is_live(q_rt) && busy[q_rt];

`ifdef GRF_WB_TRACE_EN
   always_ff @(posedge clk) begin
      if (reset && pipe_wr)
         $display("@%h: $%0d <= %h", p_pc, p_wt, p_wdata);
      else if (reset && fifo_pop)
         $display("@%h: $%0d <= %h", head.pc, head.wt, head.wdata);
   end
`endif

endmodule

// File: tb/tb_grf_wb_queue.sv
// Bench for grf_wb_queue: queue-based reference model plus directed literal scenarios.
`timescale 1ns/1ps
module tb_grf_wb_queue;

   localparam int unsigned DEPTH = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        p_we, m_valid, alloc_valid;
   logic [4:0]  p_wt, m_wt, alloc_wt, q_rs, q_rt;
   logic [31:0] p_wdata, p_pc, m_wdata, m_pc;
   logic        m_ready, q_busy_rs, q_busy_rt, WE;
   logic [4:0]  wt;
   logic [31:0] wdata, wPc;
   logic [2:0]  pending;

   int checks = 0;
   int failures = 0;
   bit run = 1'b0;

   always #5 clk = ~clk;

   grf_wb_queue #(.DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset),
      .p_we(p_we), .p_wt(p_wt), .p_wdata(p_wdata), .p_pc(p_pc),
      .m_valid(m_valid), .m_ready(m_ready), .m_wt(m_wt), .m_wdata(m_wdata), .m_pc(m_pc),
      .alloc_valid(alloc_valid), .alloc_wt(alloc_wt),
      .q_rs(q_rs), .q_rt(q_rt), .q_busy_rs(q_busy_rs), .q_busy_rt(q_busy_rt),
      .WE(WE), .wt(wt), .wdata(wdata), .wPc(wPc), .pending(pending)
   );

   typedef struct {
      logic [4:0]  wt;
      logic [31:0] wdata;
      logic [31:0] pc;
   } ent_t;

   ent_t        mq[$];
   bit          mbusy[32];
   logic        exp_we;
   logic [4:0]  exp_wt;
   logic [31:0] exp_wdata, exp_pc;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic void model_clear();
      mq.delete();
      foreach (mbusy[i]) mbusy[i] = 1'b0;
      exp_we = 1'b0;
      exp_wt = '0;
      exp_wdata = '0;
      exp_pc = '0;
   endfunction

   // Reference: port owner is pipeline, else oldest queued write, else idle.
   always @(posedge clk) begin
      bit   pipe, ready, pop;
      ent_t h;
      if (reset) begin
         pipe  = p_we && (p_wt != 0);
         ready = (mq.size() != DEPTH);
         pop   = !pipe && (mq.size() > 0);
         if (pipe) begin
            exp_we = 1'b1; exp_wt = p_wt; exp_wdata = p_wdata; exp_pc = p_pc;
         end else if (pop) begin
            h = mq.pop_front();
            exp_we = 1'b1; exp_wt = h.wt; exp_wdata = h.wdata; exp_pc = h.pc;
            mbusy[h.wt] = 1'b0;
         end else begin
            exp_we = 1'b0;
         end
         if (m_valid && ready && (m_wt != 0)) mq.push_back(ent_t'{m_wt, m_wdata, m_pc});
         if (alloc_valid && (alloc_wt != 0)) mbusy[alloc_wt] = 1'b1;
      end
   end

   always @(negedge reset) model_clear();

   always @(negedge clk) begin
      if (run) begin
         chk("m_we", 32'(WE), 32'(exp_we));
         chk("m_wt", 32'(wt), 32'(exp_wt));
         chk("m_wdata", wdata, exp_wdata);
         chk("m_wpc", wPc, exp_pc);
         chk("m_pending", 32'(pending), 32'(mq.size()));
         chk("m_ready", 32'(m_ready), 32'(mq.size() != DEPTH));
         chk("m_busy_rs", 32'(q_busy_rs), 32'((q_rs != 0) && mbusy[q_rs]));
         chk("m_busy_rt", 32'(q_busy_rt), 32'((q_rt != 0) && mbusy[q_rt]));
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      p_we = 0; p_wt = 0; p_wdata = 0; p_pc = 0;
      m_valid = 0; m_wt = 0; m_wdata = 0; m_pc = 0;
      alloc_valid = 0; alloc_wt = 0;
   endtask

   initial begin
      idle();
      q_rs = 0;
      q_rt = 0;
      model_clear();
      #12;
      run = 1'b1;
      chk("rst_we", 32'(WE), 0);
      chk("rst_wt", 32'(wt), 0);
      chk("rst_pending", 32'(pending), 0);
      chk("rst_ready", 32'(m_ready), 1);
      #10 reset = 1'b1;
      step();

      // Pipeline write appears one cycle later, then port goes idle holding data.
      p_we = 1; p_wt = 5; p_wdata = 32'h1234; p_pc = 32'h3000;
      step();
      idle();
      chk("pipe_we", 32'(WE), 1);
      chk("pipe_wt", 32'(wt), 5);
      chk("pipe_wdata", wdata, 32'h1234);
      chk("pipe_wpc", wPc, 32'h3000);
      step();
      chk("idle_we", 32'(WE), 0);
      chk("idle_hold_wt", 32'(wt), 5);
      chk("idle_hold_wdata", wdata, 32'h1234);

      // Allocate $8, then MDU result: busy until dequeued two edges after accept.
      alloc_valid = 1; alloc_wt = 8;
      step();
      idle();
      q_rs = 8;
      #1;
      chk("alloc_busy", 32'(q_busy_rs), 1);
      m_valid = 1; m_wt = 8; m_wdata = 32'hAA; m_pc = 32'h4000;
      step();
      idle();
      chk("mdu_e0_pending", 32'(pending), 1);
      chk("mdu_e0_we", 32'(WE), 0);
      chk("mdu_e0_busy", 32'(q_busy_rs), 1);
      step();
      chk("mdu_e1_we", 32'(WE), 1);
      chk("mdu_e1_wt", 32'(wt), 8);
      chk("mdu_e1_wdata", wdata, 32'hAA);
      chk("mdu_e1_wpc", wPc, 32'h4000);
      chk("mdu_e1_busy", 32'(q_busy_rs), 0);
      chk("mdu_e1_pending", 32'(pending), 0);
      step();

      // MDU $9 waits behind three pipeline writes.
      p_we = 1; p_wt = 1; p_wdata = 32'h11; p_pc = 32'h100;
      m_valid = 1; m_wt = 9; m_wdata = 32'h99; m_pc = 32'h900;
      step();
      m_valid = 0;
      chk("stall_c1_wt", 32'(wt), 1);
      p_wt = 2; p_wdata = 32'h22;
      step();
      chk("stall_c2_wt", 32'(wt), 2);
      p_wt = 3; p_wdata = 32'h33;
      step();
      chk("stall_c3_wt", 32'(wt), 3);
      chk("stall_c3_pending", 32'(pending), 1);
      idle();
      step();
      chk("stall_c4_we", 32'(WE), 1);
      chk("stall_c4_wt", 32'(wt), 9);
      chk("stall_c4_wdata", wdata, 32'h99);
      step();

      // Fill the queue under continuous pipeline writes; 5th request must wait.
      p_we = 1; p_wt = 1; p_wdata = 32'h55; p_pc = 32'h500;
      m_valid = 1;
      for (int i = 0; i < 4; i++) begin
         m_wt = 5'(10 + i); m_wdata = 32'(32'h100 + i); m_pc = 32'(32'h1000 + i);
         step();
      end
      chk("full_pending", 32'(pending), 4);
      chk("full_ready", 32'(m_ready), 0);
      m_wt = 14; m_wdata = 32'h104; m_pc = 32'h1004;
      step();
      chk("held_pending", 32'(pending), 4);
      chk("held_ready", 32'(m_ready), 0);
      chk("held_wt", 32'(wt), 1);
      p_we = 0;
      step();
      chk("drain0_wt", 32'(wt), 10);
      chk("drain0_wdata", wdata, 32'h100);
      chk("drain0_pending", 32'(pending), 3);
      step();
      m_valid = 0;
      chk("drain1_wt", 32'(wt), 11);
      chk("drain1_pending", 32'(pending), 3);
      for (int j = 12; j <= 14; j++) begin
         step();
         chk("drain_order_wt", 32'(wt), 32'(j));
         chk("drain_order_wdata", wdata, 32'(32'h100 + j - 10));
      end
      idle();
      step();
      chk("drained_we", 32'(WE), 0);
      chk("drained_pending", 32'(pending), 0);

      // Writes to $0 from either source are dropped.
      p_we = 1; p_wt = 0; p_wdata = 32'hDEAD; p_pc = 32'hBEEF;
      m_valid = 1; m_wt = 0; m_wdata = 32'hCAFE;
      step();
      idle();
      chk("zero_we", 32'(WE), 0);
      chk("zero_pending", 32'(pending), 0);
      chk("zero_hold_wt", 32'(wt), 14);
      step();
      chk("zero_we2", 32'(WE), 0);

      // Asynchronous reset with three entries queued.
      p_we = 1; p_wt = 2; p_wdata = 32'h77; p_pc = 32'h700;
      m_valid = 1; alloc_valid = 1;
      for (int i = 0; i < 3; i++) begin
         m_wt = 5'(20 + i); m_wdata = 32'(32'h200 + i); m_pc = 32'(32'h2000 + i);
         alloc_wt = 5'(20 + i);
         step();
      end
      m_valid = 0; alloc_valid = 0;
      chk("prerst_pending", 32'(pending), 3);
      q_rs = 20; q_rt = 22;
      #1;
      chk("prerst_busy", 32'(q_busy_rs), 1);
      #2 reset = 1'b0;
      #1;
      chk("rst_now_we", 32'(WE), 0);
      chk("rst_now_wt", 32'(wt), 0);
      chk("rst_now_wdata", wdata, 0);
      chk("rst_now_wpc", wPc, 0);
      chk("rst_now_pending", 32'(pending), 0);
      chk("rst_now_ready", 32'(m_ready), 1);
      chk("rst_now_busy_rs", 32'(q_busy_rs), 0);
      chk("rst_now_busy_rt", 32'(q_busy_rt), 0);
      idle();
      #3 reset = 1'b1;
      for (int k = 0; k < 3; k++) begin
         step();
         chk("postrst_we", 32'(WE), 0);
         chk("postrst_pending", 32'(pending), 0);
      end

      // Random traffic against the reference model.
      for (int c = 0; c < 3000; c++) begin
         p_we        = ($urandom_range(0, 9) < 5);
         p_wt        = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
         p_wdata     = $urandom;
         p_pc        = $urandom;
         m_valid     = ($urandom_range(0, 9) < 6);
         m_wt        = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
         m_wdata     = $urandom;
         m_pc        = $urandom;
         alloc_valid = ($urandom_range(0, 3) == 0);
         alloc_wt    = 5'($urandom);
         q_rs        = 5'($urandom);
         q_rt        = 5'($urandom);
         if ($urandom_range(0, 499) == 0) begin
            reset = 1'b0;
            #2 reset = 1'b1;
         end
         step();
      end
      idle();
      for (int d = 0; d < 10; d++) step();
      chk("final_pending", 32'(pending), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
